// File: rtl/adder_bist_16bit.sv
// Built-in self-test sequencer for an external 16-bit adder: drives operand vectors,
// waits for the adder to settle, compares against a reference sum and counts mismatches.
module adder_bist_16bit #(
    parameter int unsigned SETTLE_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [7:0]  num_vectors,
    output logic [15:0] dut_a,
    output logic [15:0] dut_b,
    output logic        dut_carry_in,
    input  logic [15:0] dut_sum,
    input  logic        dut_overflow,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [7:0]  error_count
);

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] LOAD  = 3'd1;
    localparam logic [2:0] WAIT  = 3'd2;
    localparam logic [2:0] CHECK = 3'd3;
    localparam logic [2:0] DONE  = 3'd4;

    localparam logic [15:0] SEED_A    = 16'hACE1;
    localparam logic [15:0] SEED_B    = 16'h1D2C;
    localparam logic [3:0]  WAIT_LAST = 4'(SETTLE_CYCLES - 1);

    logic [2:0]  state_q, state_d;
    logic [7:0]  count_q, count_d;
    logic [7:0]  index_q, index_d;
    logic [3:0]  waitCnt_q, waitCnt_d;
    logic [15:0] lfsrA_q, lfsrA_d;
    logic [15:0] lfsrB_q, lfsrB_d;
    logic [15:0] a_q, a_d;
    logic [15:0] b_q, b_d;
    logic        cin_q, cin_d;
    logic        pass_q, pass_d;
    logic [7:0]  errCount_q, errCount_d;

    logic [16:0] expected;
    logic        mismatch;
    logic [7:0]  errNext;

    function automatic logic [15:0] lfsrNext(input logic [15:0] q);
        return {q[14:0], q[15] ^ q[13] ^ q[12] ^ q[10]};
    endfunction

    assign expected = {1'b0, a_q} + {1'b0, b_q} + {16'd0, cin_q};
    assign mismatch = (dut_sum != expected[15:0]) || (dut_overflow != expected[16]);
    // The counter saturates rather than wrapping, although a run can never exceed 255 vectors.
    assign errNext  = (mismatch && (errCount_q != 8'hFF)) ? errCount_q + 8'd1 : errCount_q;

    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        index_d    = index_q;
        waitCnt_d  = waitCnt_q;
        lfsrA_d    = lfsrA_q;
        lfsrB_d    = lfsrB_q;
        a_d        = a_q;
        b_d        = b_q;
        cin_d      = cin_q;
        pass_d     = pass_q;
        errCount_d = errCount_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    count_d    = num_vectors;
                    errCount_d = 8'd0;
                    pass_d     = 1'b0;
                    index_d    = 8'd0;
                    lfsrA_d    = SEED_A;
                    lfsrB_d    = SEED_B;
                    if (num_vectors != 8'd0) begin
                        state_d = LOAD;
                    end else begin
                        state_d = DONE;
                        pass_d  = 1'b1;
                    end
                end
            end
            LOAD: begin
                // Two fixed corner vectors come first, then the pseudo-random ones.
                if (index_q == 8'd0) begin
                    a_d   = 16'h0000;
                    b_d   = 16'h0000;
                    cin_d = 1'b0;
                end else if (index_q == 8'd1) begin
                    a_d   = 16'hFFFF;
                    b_d   = 16'hFFFF;
                    cin_d = 1'b1;
                end else begin
                    a_d     = lfsrA_q;
                    b_d     = lfsrB_q;
                    cin_d   = lfsrA_q[0] ^ lfsrB_q[0];
                    lfsrA_d = lfsrNext(lfsrA_q);
                    lfsrB_d = lfsrNext(lfsrB_q);
                end
                waitCnt_d = 4'd0;
                state_d   = WAIT;
            end
            WAIT: begin
                if (waitCnt_q == WAIT_LAST) begin
                    state_d = CHECK;
                end else begin
                    waitCnt_d = waitCnt_q + 4'd1;
                end
            end
            CHECK: begin
                errCount_d = errNext;
                if (index_q == count_q - 8'd1) begin
                    state_d = DONE;
                    pass_d  = (errNext == 8'd0);
                end else begin
                    index_d = index_q + 8'd1;
                    state_d = LOAD;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            count_q    <= 8'd0;
            index_q    <= 8'd0;
            waitCnt_q  <= 4'd0;
            lfsrA_q    <= SEED_A;
            lfsrB_q    <= SEED_B;
            a_q        <= 16'h0000;
            b_q        <= 16'h0000;
            cin_q      <= 1'b0;
            pass_q     <= 1'b0;
            errCount_q <= 8'd0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            index_q    <= index_d;
            waitCnt_q  <= waitCnt_d;
            lfsrA_q    <= lfsrA_d;
            lfsrB_q    <= lfsrB_d;
            a_q        <= a_d;
            b_q        <= b_d;
            cin_q      <= cin_d;
            pass_q     <= pass_d;
            errCount_q <= errCount_d;
        end
    end

    assign dut_a        = a_q;
    assign dut_b        = b_q;
    assign dut_carry_in = cin_q;
    assign busy         = (state_q == LOAD) || (state_q == WAIT) || (state_q == CHECK);
    assign done         = (state_q == DONE);
    assign pass         = pass_q;
    assign error_count  = errCount_q;

endmodule

// File: tb/tb_adder_bist_16bit.sv
// Bench for adder_bist_16bit: an adder with selectable faults sits on the DUT side,
// and run timing, operand vectors and verdicts are predicted from the vector rules.
module tb_adder_bist_16bit;

    localparam int S = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [7:0]  numVectors;
    logic [15:0] dutA, dutB, dutSum;
    logic        dutCin, dutOverflow;
    logic        busy, done, pass;
    logic [7:0]  errorCount;

    int faultMode = 0;
    int errors = 0;
    int checks = 0;

    logic [15:0] expA [0:254];
    logic [15:0] expB [0:254];
    logic        expC [0:254];

    adder_bist_16bit #(.SETTLE_CYCLES(S)) dut (
        .clk(clk), .rst(rst), .start(start), .num_vectors(numVectors),
        .dut_a(dutA), .dut_b(dutB), .dut_carry_in(dutCin),
        .dut_sum(dutSum), .dut_overflow(dutOverflow),
        .busy(busy), .done(done), .pass(pass), .error_count(errorCount)
    );

    always #5 clk = ~clk;

    // Adder under test: mode 0 ideal, 1 sum bit 0 stuck at 0, 2 all outputs tied low.
    function automatic logic [16:0] adderOut(input int mode, input logic [16:0] ideal);
        if (mode == 1) return ideal & 17'h1FFFE;
        if (mode == 2) return 17'h00000;
        return ideal;
    endfunction

    logic [16:0] trueSum, faultySum;
    assign trueSum   = {1'b0, dutA} + {1'b0, dutB} + {16'd0, dutCin};
    assign faultySum = adderOut(faultMode, trueSum);
    assign dutSum      = faultySum[15:0];
    assign dutOverflow = faultySum[16];

    function automatic logic [15:0] lfsrStep(input logic [15:0] x);
        return {x[14:0], x[15] ^ x[13] ^ x[12] ^ x[10]};
    endfunction

    task automatic buildVectors();
        logic [15:0] la, lb;
        la = 16'hACE1;
        lb = 16'h1D2C;
        expA[0] = 16'h0000; expB[0] = 16'h0000; expC[0] = 1'b0;
        expA[1] = 16'hFFFF; expB[1] = 16'hFFFF; expC[1] = 1'b1;
        for (int v = 2; v < 255; v++) begin
            expA[v] = la;
            expB[v] = lb;
            expC[v] = la[0] ^ lb[0];
            la = lfsrStep(la);
            lb = lfsrStep(lb);
        end
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One full run started at cycle 0; every later cycle is checked against the timing rules.
    task automatic applyStimulus(input int n, input int mode, input bit repulse);
        int doneCycle, expErr, v, runLen;
        logic [16:0] ideal;
        faultMode = mode;
        runLen    = n * (S + 2);
        doneCycle = (n == 0) ? 1 : runLen + 1;
        expErr    = 0;
        for (int i = 0; i < n; i++) begin
            ideal = {1'b0, expA[i]} + {1'b0, expB[i]} + {16'd0, expC[i]};
            if (adderOut(mode, ideal) != ideal) expErr++;
        end
        if (expErr > 255) expErr = 255;
        $display("[TB] run n=%0d fault=%0d repulse=%0d expect errors=%0d done@%0d",
                 n, mode, repulse, expErr, doneCycle);
        @(negedge clk);
        start      = 1'b1;
        numVectors = 8'(n);
        @(posedge clk);
        #1 start   = 1'b0;
        numVectors = 8'($urandom_range(0, 255));
        for (int k = 1; k <= doneCycle + 1; k++) begin
            @(negedge clk);
            start = (repulse && k == 3) ? 1'b1 : 1'b0;
            if (repulse && k == 3) numVectors = 8'd1;
            checkOutput($sformatf("busy@%0d", k), 32'(busy), 32'((n != 0) && (k <= runLen)));
            checkOutput($sformatf("done@%0d", k), 32'(done), 32'(k == doneCycle));
            if (n != 0 && k >= 2 && k <= runLen && ((k - 2) % (S + 2)) == S) begin
                v = (k - 2) / (S + 2);
                checkOutput($sformatf("dut_a v%0d", v), 32'(dutA), 32'(expA[v]));
                checkOutput($sformatf("dut_b v%0d", v), 32'(dutB), 32'(expB[v]));
                checkOutput($sformatf("dut_cin v%0d", v), 32'(dutCin), 32'(expC[v]));
            end
            if (k == doneCycle) begin
                checkOutput("pass at done", 32'(pass), 32'(expErr == 0));
                checkOutput("error_count at done", 32'(errorCount), 32'(expErr));
            end
        end
        start = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("pass held in idle", 32'(pass), 32'(expErr == 0));
        checkOutput("error_count held in idle", 32'(errorCount), 32'(expErr));
        checkOutput("idle not busy", 32'(busy), 32'd0);
    endtask

    initial begin
        buildVectors();
        rst        = 1'b1;
        start      = 1'b0;
        numVectors = 8'd0;
        repeat (3) @(negedge clk);
        checkOutput("reset busy", 32'(busy), 32'd0);
        checkOutput("reset done", 32'(done), 32'd0);
        checkOutput("reset pass", 32'(pass), 32'd0);
        checkOutput("reset error_count", 32'(errorCount), 32'd0);
        checkOutput("reset dut_a", 32'(dutA), 32'd0);
        checkOutput("reset dut_b", 32'(dutB), 32'd0);
        checkOutput("reset dut_cin", 32'(dutCin), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        applyStimulus(3, 0, 1'b0);
        applyStimulus(2, 1, 1'b0);
        applyStimulus(0, 0, 1'b0);

        // Reset lands in the WAIT of vector 1 of a three-vector run.
        faultMode = 0;
        @(negedge clk);
        start      = 1'b1;
        numVectors = 8'd3;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (6) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checkOutput("rst mid-run busy", 32'(busy), 32'd0);
        checkOutput("rst mid-run dut_a", 32'(dutA), 32'd0);
        checkOutput("rst mid-run error_count", 32'(errorCount), 32'd0);
        checkOutput("rst mid-run done", 32'(done), 32'd0);
        @(negedge clk);
        checkOutput("after rst no done", 32'(done), 32'd0);
        applyStimulus(1, 0, 1'b0);

        applyStimulus(3, 0, 1'b1);
        applyStimulus(255, 2, 1'b0);

        for (int r = 0; r < 6; r++) begin
            applyStimulus(int'($urandom_range(0, 24)), int'($urandom_range(0, 2)),
                          1'($urandom_range(0, 1)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
